// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   ID/EX pipeline stage in front of the ALU. It decodes ALUOp and funct into
//   a 4-bit ALUctl code, then selects and extends the A/B operands. The result
//   is registered into EX. BEQ/BNE are resolved from the ALU Zero output, and
//   a taken branch squashes the wrong-path instruction being loaded.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-low reset
//   valid_i              ID instruction present
//   stall_i, flush_i     hold EX / load a bubble (flush wins over stall)
//   alu_op_i, funct_i    main-decoder ALUOp and instruction[5:0]
//   rs_data_i, rt_data_i register-file operands
//   imm_i, rd_i          instruction[15:0], destination register
//   zero_i               ALU Zero result for the EX instruction
//   alu_ctl_o, a_o, b_o  registered ALU control and operands
//   valid_o, rd_o        EX valid and destination register
//   illegal_o            EX instruction had an undefined R-type funct
//   branch_taken_o       combinational branch resolution
//   issue_cnt_o          instructions loaded (wraps)
//   illegal_cnt_o        illegal instructions loaded (wraps)
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [2:0]        alu_op_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [15:0]       imm_i,
  input  logic [4:0]        rd_i,
  input  logic              zero_i,
  output logic [3:0]        alu_ctl_o,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic              valid_o,
  output logic [4:0]        rd_o,
  output logic              illegal_o,
  output logic              branch_taken_o,
  output logic [CNT_W-1:0]  issue_cnt_o,
  output logic [CNT_W-1:0]  illegal_cnt_o
);

  localparam logic [2:0] OP_MEM  = 3'd0;
  localparam logic [2:0] OP_BEQ  = 3'd1;
  localparam logic [2:0] OP_RTYP = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_SLTI = 3'd4;
  localparam logic [2:0] OP_LUI  = 3'd5;
  localparam logic [2:0] OP_ORI  = 3'd6;
  localparam logic [2:0] OP_BNE  = 3'd7;

  // Returns {illegal, ALUctl}. Only R-type can be illegal.
  function automatic logic [4:0] decode_ctl(input logic [2:0] op, input logic [5:0] fn);
    logic [4:0] r;
    r = 5'b0_0000;
    case (op)
      OP_MEM, OP_ADDI: r = {1'b0, 4'd2};
      OP_BEQ, OP_BNE:  r = {1'b0, 4'd6};
      OP_SLTI:         r = {1'b0, 4'd7};
      OP_LUI:          r = {1'b0, 4'd5};
      OP_ORI:          r = {1'b0, 4'd8};
      default: begin
        case (fn)
          6'h20:   r = {1'b0, 4'd2};
          6'h22:   r = {1'b0, 4'd6};
          6'h24:   r = {1'b0, 4'd0};
          6'h25:   r = {1'b0, 4'd1};
          6'h2A:   r = {1'b0, 4'd7};
          6'h06:   r = {1'b0, 4'd3};
          6'h18:   r = {1'b0, 4'd10};
          default: r = {1'b1, 4'd0};
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    return {{(DATA_W-16){1'b0}}, v};
  endfunction

  // ---- stage p0: ID decode and operand select ----
  logic [3:0]        ctl_p0;
  logic              ill_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic              beq_p0;
  logic              bne_p0;

  always_comb begin
    {ill_p0, ctl_p0} = decode_ctl(alu_op_i, funct_i);
    // LUI feeds the immediate through B with A forced to zero. SRLV keeps A=rs
    // because the ALU computes B>>A, so A carries the shift amount.
    a_p0 = (alu_op_i == OP_LUI) ? '0 : rs_data_i;
    case (alu_op_i)
      OP_MEM, OP_ADDI, OP_SLTI: b_p0 = sext16(imm_i);
      OP_LUI, OP_ORI:           b_p0 = zext16(imm_i);
      default:                  b_p0 = rt_data_i;
    endcase
    // Flags are masked by valid_i so that a non-instruction cannot resolve as a branch.
    beq_p0 = valid_i & (alu_op_i == OP_BEQ);
    bne_p0 = valid_i & (alu_op_i == OP_BNE);
  end

  // ---- stage p1: EX register ----
  logic              vld_p1;
  logic [3:0]        ctl_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic              ill_p1;
  logic [4:0]        rd_p1;
  logic              beq_p1;
  logic              bne_p1;
  logic [CNT_W-1:0]  issue_cnt_p1;
  logic [CNT_W-1:0]  illegal_cnt_p1;
  logic              taken;
  logic              bubble;
  logic              load;

  assign taken  = vld_p1 & ((beq_p1 & zero_i) | (bne_p1 & ~zero_i));
  assign bubble = flush_i | taken;
  assign load   = ~bubble & ~stall_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p1         <= 1'b0;
      ctl_p1         <= '0;
      a_p1           <= '0;
      b_p1           <= '0;
      ill_p1         <= 1'b0;
      rd_p1          <= '0;
      beq_p1         <= 1'b0;
      bne_p1         <= 1'b0;
      issue_cnt_p1   <= '0;
      illegal_cnt_p1 <= '0;
    end else if (bubble) begin
      vld_p1 <= 1'b0;
      ctl_p1 <= '0;
      a_p1   <= '0;
      b_p1   <= '0;
      ill_p1 <= 1'b0;
      rd_p1  <= '0;
      beq_p1 <= 1'b0;
      bne_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= valid_i;
      ctl_p1 <= ctl_p0;
      a_p1   <= a_p0;
      b_p1   <= b_p0;
      ill_p1 <= ill_p0;
      rd_p1  <= rd_i;
      beq_p1 <= beq_p0;
      bne_p1 <= bne_p0;
      if (valid_i) begin
        issue_cnt_p1 <= issue_cnt_p1 + 1'b1;
        if (ill_p0) illegal_cnt_p1 <= illegal_cnt_p1 + 1'b1;
      end
    end
  end

  assign alu_ctl_o      = ctl_p1;
  assign a_o            = a_p1;
  assign b_o            = b_p1;
  assign valid_o        = vld_p1;
  assign rd_o           = rd_p1;
  assign illegal_o      = ill_p1;
  assign branch_taken_o = taken;
  assign issue_cnt_o    = issue_cnt_p1;
  assign illegal_cnt_o  = illegal_cnt_p1;

endmodule
